// File: rtl/x_dbladd.sv
// x_dbladd: combined x-only point doubling and differential addition
// (R = 2P, S = P+Q) for Montgomery-form curves. Every field operation is
// sequenced onto one external modular arithmetic unit; this block only
// selects operands, runs the handshake and stores the results.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | held in reset; leaves on the first clock with rst low
// ISSUE | register operands/op for the current step, drop rst_mul
// WAIT  | operands held; capture mul into dst when done_mul arrives
// NEXT  | unit re-arming (rst_mul high); advance step
// DONE  | results valid; everything frozen until rst
module x_dbladd #(
  parameter int N = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Px,
  input  logic [N-1:0] Pz,
  input  logic [N-1:0] Qx,
  input  logic [N-1:0] Qz,
  input  logic [N-1:0] PQx,
  input  logic [N-1:0] PQz,
  input  logic [N-1:0] Ax,
  input  logic [N-1:0] Az,
  output logic [N-1:0] Rx,
  output logic [N-1:0] Rz,
  output logic [N-1:0] Sx,
  output logic [N-1:0] Sz,
  output logic         done,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [1:0]   op,
  output logic         rst_mul,
  input  logic [N-1:0] mul,
  input  logic         done_mul
);

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  // operand sources
  localparam logic [3:0] S_A   = 4'd0;
  localparam logic [3:0] S_B   = 4'd1;
  localparam logic [3:0] S_C   = 4'd2;
  localparam logic [3:0] S_D   = 4'd3;
  localparam logic [3:0] S_RX  = 4'd4;
  localparam logic [3:0] S_RZ  = 4'd5;
  localparam logic [3:0] S_SX  = 4'd6;
  localparam logic [3:0] S_SZ  = 4'd7;
  localparam logic [3:0] S_PX  = 4'd8;
  localparam logic [3:0] S_PZ  = 4'd9;
  localparam logic [3:0] S_QX  = 4'd10;
  localparam logic [3:0] S_QZ  = 4'd11;
  localparam logic [3:0] S_PQX = 4'd12;
  localparam logic [3:0] S_PQZ = 4'd13;
  localparam logic [3:0] S_AX  = 4'd14;
  localparam logic [3:0] S_AZ  = 4'd15;

  // result destinations
  localparam logic [2:0] D_A  = 3'd0;
  localparam logic [2:0] D_B  = 3'd1;
  localparam logic [2:0] D_C  = 3'd2;
  localparam logic [2:0] D_D  = 3'd3;
  localparam logic [2:0] D_RX = 3'd4;
  localparam logic [2:0] D_RZ = 3'd5;
  localparam logic [2:0] D_SX = 3'd6;
  localparam logic [2:0] D_SZ = 3'd7;

  localparam logic [4:0] LAST_STEP = 5'd22;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

  state_t       r_state;
  logic [4:0]   r_step;
  logic [N-1:0] r_a, r_b, r_c, r_d;
  logic [N-1:0] r_rx, r_rz, r_sx, r_sz;
  logic [N-1:0] r_A, r_B;
  logic [1:0]   r_op;
  logic         r_rst_mul;
  logic         r_done;

  logic [1:0]   w_op;
  logic [3:0]   w_src_a, w_src_b;
  logic [2:0]   w_dst;
  logic [N-1:0] w_opa, w_opb;

  function automatic logic [N-1:0] f_sel(input logic [3:0] s);
    logic [N-1:0] v;
    case (s)
      S_A:     v = r_a;
      S_B:     v = r_b;
      S_C:     v = r_c;
      S_D:     v = r_d;
      S_RX:    v = r_rx;
      S_RZ:    v = r_rz;
      S_SX:    v = r_sx;
      S_SZ:    v = r_sz;
      S_PX:    v = Px;
      S_PZ:    v = Pz;
      S_QX:    v = Qx;
      S_QZ:    v = Qz;
      S_PQX:   v = PQx;
      S_PQZ:   v = PQz;
      S_AX:    v = Ax;
      default: v = Az;
    endcase
    return v;
  endfunction

  // Step program: operation, two sources and destination per step
  always_comb begin
    {w_op, w_src_a, w_src_b, w_dst} = {OP_ADD, S_QX, S_QZ, D_A};
    case (r_step)
      5'd0:  {w_op, w_src_a, w_src_b, w_dst} = {OP_ADD, S_QX,  S_QZ,  D_A};
      5'd1:  {w_op, w_src_a, w_src_b, w_dst} = {OP_SUB, S_QX,  S_QZ,  D_B};
      5'd2:  {w_op, w_src_a, w_src_b, w_dst} = {OP_ADD, S_PX,  S_PZ,  D_C};
      5'd3:  {w_op, w_src_a, w_src_b, w_dst} = {OP_SUB, S_PX,  S_PZ,  D_D};
      5'd4:  {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_C,   S_C,   D_RX};
      5'd5:  {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_D,   S_D,   D_SX};
      5'd6:  {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_C,   S_B,   D_C};
      5'd7:  {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_D,   S_A,   D_D};
      5'd8:  {w_op, w_src_a, w_src_b, w_dst} = {OP_SUB, S_RX,  S_SX,  D_B};
      5'd9:  {w_op, w_src_a, w_src_b, w_dst} = {OP_ADD, S_AZ,  S_AZ,  D_A};
      5'd10: {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_A,   S_SX,  D_RZ};
      5'd11: {w_op, w_src_a, w_src_b, w_dst} = {OP_ADD, S_AX,  S_A,   D_SX};
      5'd12: {w_op, w_src_a, w_src_b, w_dst} = {OP_ADD, S_RZ,  S_RZ,  D_RZ};
      5'd13: {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_RX,  S_RZ,  D_RX};
      5'd14: {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_SX,  S_B,   D_SX};
      5'd15: {w_op, w_src_a, w_src_b, w_dst} = {OP_SUB, S_D,   S_C,   D_SZ};
      5'd16: {w_op, w_src_a, w_src_b, w_dst} = {OP_ADD, S_RZ,  S_SX,  D_RZ};
      5'd17: {w_op, w_src_a, w_src_b, w_dst} = {OP_ADD, S_C,   S_D,   D_SX};
      5'd18: {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_RZ,  S_B,   D_RZ};
      5'd19: {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_SZ,  S_SZ,  D_SZ};
      5'd20: {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_SX,  S_SX,  D_SX};
      5'd21: {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_SX,  S_PQZ, D_SX};
      5'd22: {w_op, w_src_a, w_src_b, w_dst} = {OP_MUL, S_SZ,  S_PQX, D_SZ};
      default: ;
    endcase
  end

  // Operand fetch for the current step
  always_comb begin
    w_opa = f_sel(w_src_a);
    w_opb = f_sel(w_src_b);
  end

  // Sequencer: issue/wait/capture handshake with the shared unit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_rx      <= '0;
      r_rz      <= '0;
      r_sx      <= '0;
      r_sz      <= '0;
      r_A       <= '0;
      r_B       <= '0;
      r_op      <= OP_MUL;
      r_rst_mul <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_step  <= '0;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_A       <= w_opa;
          r_B       <= w_opb;
          r_op      <= w_op;
          r_rst_mul <= 1'b0;
          r_state   <= WAIT;
        end
        WAIT: begin
          // done_mul is only meaningful while the unit is armed
          if (done_mul && !r_rst_mul) begin
            case (w_dst)
              D_A:     r_a  <= mul;
              D_B:     r_b  <= mul;
              D_C:     r_c  <= mul;
              D_D:     r_d  <= mul;
              D_RX:    r_rx <= mul;
              D_RZ:    r_rz <= mul;
              D_SX:    r_sx <= mul;
              default: r_sz <= mul;
            endcase
            r_rst_mul <= 1'b1;
            r_state   <= NEXT;
          end
        end
        NEXT: begin
          r_step  <= r_step + 5'd1;
          r_state <= (r_step == LAST_STEP) ? DONE : ISSUE;
        end
        DONE: begin
          r_done <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Rx      = r_rx;
  assign Rz      = r_rz;
  assign Sx      = r_sx;
  assign Sz      = r_sz;
  assign done    = r_done;
  assign A       = r_A;
  assign B       = r_B;
  assign op      = r_op;
  assign rst_mul = r_rst_mul;

endmodule

// File: tb/tb_x_dbladd.sv
// Bench for x_dbladd: a behavioural shared arithmetic unit (plain integer
// product mod p, configurable latency/stalls/spurious pulses), an issue
// monitor, and a scoreboard that checks results and latency on done.
module tb_x_dbladd;

  localparam int N = 512;
  localparam logic [N-1:0] P_MOD = {N{1'b1}} - 512'd568;

  logic         clk;
  logic         rst;
  logic [N-1:0] Px, Pz, Qx, Qz, PQx, PQz, Ax, Az;
  logic [N-1:0] Rx, Rz, Sx, Sz;
  logic         done;
  logic [N-1:0] A, B;
  logic [1:0]   op;
  logic         rst_mul;
  logic [N-1:0] mul;
  logic         done_mul;

  x_dbladd #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .Px(Px), .Pz(Pz), .Qx(Qx), .Qz(Qz), .PQx(PQx), .PQz(PQz), .Ax(Ax), .Az(Az),
    .Rx(Rx), .Rz(Rz), .Sx(Sx), .Sz(Sz), .done(done),
    .A(A), .B(B), .op(op), .rst_mul(rst_mul), .mul(mul), .done_mul(done_mul)
  );

  typedef struct {
    logic [N-1:0] rx, rz, sx, sz;
    int           base_cyc;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  int lat      = 1;
  int stall_en = 0;
  int spur_en  = 0;
  int stalls   = 0;
  int fall_cnt = 0;
  int cyc      = 0;
  logic [N-1:0] res4;

  logic [1:0] exp_op [0:22] = '{2'd1, 2'd2, 2'd1, 2'd2,
                                2'd0, 2'd0, 2'd0, 2'd0,
                                2'd2, 2'd1, 2'd0, 2'd1, 2'd1,
                                2'd0, 2'd0, 2'd2, 2'd1, 2'd1,
                                2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] rand_n();
    logic [N-1:0] r;
    for (int i = 0; i < N/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [N-1:0] unit_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [1:0] o);
    logic [2*N-1:0] prod;
    logic [N:0]     s;
    case (o)
      2'b00: begin
        prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        prod = prod % {{N{1'b0}}, P_MOD};
        return prod[N-1:0];
      end
      2'b01: begin
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
        return s[N-1:0];
      end
      2'b10: begin
        if (a >= b) return a - b;
        return a + (P_MOD - b);
      end
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // edge counter since rst deassertion
  initial forever begin
    @(posedge clk);
    if (rst) cyc = 0;
    else cyc = cyc + 1;
  end

  // shared-unit model and issue monitor
  initial begin : unit_model
    int cnt;
    bit got;
    logic prev_rm;
    logic [N-1:0] la, lb;
    logic [1:0] lo;
    done_mul = 1'b0;
    mul = '0;
    cnt = 0;
    got = 0;
    prev_rm = 1'b1;
    la = '0; lb = '0; lo = '0;
    forever begin
      @(negedge clk);
      if (prev_rm === 1'b1 && rst_mul === 1'b0) begin
        n_cmp++;
        if (fall_cnt >= 23) begin
          n_bad++;
          $display("FAIL extra_issue: issue #%0d beyond 23", fall_cnt + 1);
        end else if (op !== exp_op[fall_cnt]) begin
          n_bad++;
          $display("FAIL issue_op step %0d: got %0d expected %0d", fall_cnt + 1, op, exp_op[fall_cnt]);
        end
        fall_cnt++;
        la = A; lb = B; lo = op;
      end else if (rst_mul === 1'b0) begin
        n_cmp++;
        if (A !== la || B !== lb || op !== lo) begin
          n_bad++;
          $display("FAIL hold_stable step %0d: op %0d expected %0d", fall_cnt, op, lo);
        end
      end
      prev_rm = rst_mul;
      if (rst_mul !== 1'b0) begin
        cnt = 0;
        got = 0;
        done_mul = (spur_en != 0);
        mul = (spur_en != 0) ? rand_n() : '0;
      end else begin
        cnt++;
        if (!got) begin
          done_mul = 1'b0;
          if (cnt >= lat) begin
            if (stall_en != 0 && $urandom_range(0, 3) == 0) begin
              stalls++;
            end else begin
              got = 1;
              mul = unit_f(A, B, op);
              if (fall_cnt == 4) res4 = mul;
              done_mul = 1'b1;
            end
          end
        end
      end
    end
  end

  // scoreboard monitor: compare on every rising done
  initial begin : sb_monitor
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_q !== 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: no expected entry");
        end else begin
          e = sb.pop_front();
          chk("Rx", Rx, e.rx);
          chk("Rz", Rz, e.rz);
          chk("Sx", Sx, e.sx);
          chk("Sz", Sz, e.sz);
          n_cmp++;
          if (cyc != e.base_cyc + stalls) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc, e.base_cyc + stalls);
          end
        end
      end
      done_q = done;
    end
  end

  task automatic set_inputs(input int px, input int pz);
    Px = N'(px); Pz = N'(pz);
    Qx = N'(2);  Qz = N'(1);
    PQx = N'(1); PQz = N'(1);
    Ax = N'(0);  Az = N'(1);
  endtask

  // one full computation: push expectation, release reset, wait for done
  task automatic run(input int l, input int st, input int sp,
                     input int erx, input int erz, input int esx, input int esz);
    exp_t e;
    bit ok;
    if (rst !== 1'b1) begin
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
    end
    lat = l;
    stall_en = st;
    spur_en = sp;
    stalls = 0;
    fall_cnt = 0;
    e.rx = N'(erx); e.rz = N'(erz); e.sx = N'(esx); e.sz = N'(esz);
    e.base_cyc = 23 * (l + 2) + 2;
    sb.push_back(e);
    rst = 1'b0;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL done_timeout: done=%0b after 4000 cycles, expected 1", done);
      void'(sb.pop_back());
    end
    n_cmp++;
    if (fall_cnt != 23) begin
      n_bad++;
      $display("FAIL issue_count: got %0d expected 23", fall_cnt);
    end
    spur_en = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_Rx"}, Rx, '0);
    chk({tag, "_Rz"}, Rz, '0);
    chk({tag, "_Sx"}, Sx, '0);
    chk({tag, "_Sz"}, Sz, '0);
    chk({tag, "_A"}, A, '0);
    chk({tag, "_B"}, B, '0);
    chk({tag, "_op"}, N'(op), '0);
    chk({tag, "_done"}, N'(done), '0);
    chk({tag, "_rst_mul"}, N'(rst_mul), N'(1));
  endtask

  initial begin
    rst = 1'b0;
    Px = '0; Pz = '0; Qx = '0; Qz = '0; PQx = '0; PQz = '0; Ax = '0; Az = '0;
    res4 = '0;
    #1 rst = 1'b1;

    // reset held with arbitrary inputs and spurious unit pulses
    fall_cnt = 0;
    spur_en = 1;
    for (int k = 0; k < 4; k++) begin
      Px = rand_n(); Pz = rand_n(); Qx = rand_n(); Qz = rand_n();
      PQx = rand_n(); PQz = rand_n(); Ax = rand_n(); Az = rand_n();
      @(negedge clk);
      chk_reset_state("rst_hold");
    end
    spur_en = 0;
    n_cmp++;
    if (fall_cnt != 0) begin
      n_bad++;
      $display("FAIL rst_no_issue: got %0d falls expected 0", fall_cnt);
    end

    // known result, 1-cycle unit
    set_inputs(3, 1);
    run(1, 0, 0, 256, 480, 100, 4);

    // wrap-around subtraction in step 4 (d = 1 - 3)
    set_inputs(1, 3);
    res4 = '0;
    run(1, 0, 0, 256, 480, 4, 100);
    chk("step4_d", res4, P_MOD - 512'd2);

    // latency independence, spurious pulses and random stalls
    set_inputs(3, 1);
    run(7, 0, 1, 256, 480, 100, 4);
    run(40, 0, 0, 256, 480, 100, 4);
    run(7, 1, 0, 256, 480, 100, 4);
    run(1, 1, 1, 256, 480, 100, 4);

    // abort during WAIT of step 9
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    lat = 40;
    stall_en = 0;
    fall_cnt = 0;
    rst = 1'b0;
    for (int i = 0; i < 2000 && fall_cnt < 9; i++) @(negedge clk);
    n_cmp++;
    if (fall_cnt != 9) begin
      n_bad++;
      $display("FAIL abort_reach_step9: got %0d issues expected 9", fall_cnt);
    end
    repeat (5) @(negedge clk);
    chk("pre_abort_Rx", Rx, N'(16));
    #2 rst = 1'b1;
    #1 chk_reset_state("abort_async");
    spur_en = 1;
    repeat (3) @(negedge clk);
    chk_reset_state("abort_hold");
    spur_en = 0;
    run(1, 0, 0, 256, 480, 100, 4);

    // spurious done_mul while frozen in DONE
    spur_en = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("done_hold", N'(done), N'(1));
      chk("frozen_Rx", Rx, N'(256));
      chk("frozen_Rz", Rz, N'(480));
      chk("frozen_Sx", Sx, N'(100));
      chk("frozen_Sz", Sz, N'(4));
    end
    spur_en = 0;

    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/x_dbladd.md
X_DBLADD -- requirements
Module: x_dbladd

Interface
REQ-001 The block SHALL have parameter N = 512, the field element width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset, also the start control; the computation runs while rst is low.
REQ-005 Ports Px, Pz, input, N bits: point P in projective x-only form, Montgomery domain.
REQ-006 Ports Qx, Qz, input, N bits: point Q.
REQ-007 Ports PQx, PQz, input, N bits: the difference point P-Q.
REQ-008 Ports Ax, Az, input, N bits: the curve constant in projective form.
REQ-009 Ports Rx, Rz, Sx, Sz, output, N bits: the results R = 2P and S = P+Q.
REQ-010 Port done, output, 1 bit: the results are valid.
REQ-011 Ports A and B, output, N bits: operands driven to the shared modular arithmetic unit.
REQ-012 Port op, output, 2 bits: shared-unit operation; 00 = Montgomery multiply, 01 = add mod p, 10 = sub mod p (A-B), 11 = never issued.
REQ-013 Port rst_mul, output, 1 bit: shared-unit reset/start; high = idle, low = operation in progress.
REQ-014 Port mul, input, N bits: shared-unit result.
REQ-015 Port done_mul, input, 1 bit: the shared-unit result on mul is valid.

Function
REQ-016 The block SHALL execute exactly 23 steps in this order (dst = srcA op srcB):
  - 1-4: a=Qx+Qz; b=Qx-Qz; c=Px+Pz; d=Px-Pz
  - 5-8: Rx=c*c; Sx=d*d; c=c*b; d=d*a
  - 9-13: b=Rx-Sx; a=Az+Az; Rz=a*Sx; Sx=Ax+a; Rz=Rz+Rz
  - 14-18: Rx=Rx*Rz; Sx=Sx*b; Sz=d-c; Rz=Rz+Sx; Sx=c+d
  - 19-23: Rz=Rz*b; Sz=Sz*Sz; Sx=Sx*Sx; Sx=Sx*PQz; Sz=Sz*PQx
REQ-017 Internal temporaries a, b, c, d SHALL be N-bit registers; all arithmetic SHALL be delegated to the shared unit, with no local adders or multipliers.
REQ-018 Each step SHALL follow this handshake:
  - ISSUE: drive A, B, op for the step and set rst_mul = 0.
  - WAIT: hold A, B, op stable until a cycle with done_mul = 1 and rst_mul = 0.
  - CAPTURE: in that cycle register mul into dst and set rst_mul = 1.
REQ-019 rst_mul SHALL stay high for at least one full cycle between consecutive steps, so the shared unit re-arms.
REQ-020 done_mul SHALL be ignored whenever rst_mul = 1.
REQ-021 The state machine SHALL use states IDLE, ISSUE, WAIT, NEXT and DONE.
  - IDLE is entered on reset.
  - The first clock with rst low moves to ISSUE with step 0.
  - WAIT moves to NEXT on capture.
  - NEXT increments step, then goes to ISSUE, or to DONE after step 23.
  - DONE sets done = 1 and holds it, with all outputs frozen, until rst.
REQ-022 Latency from rst deassertion to done SHALL be the sum over the 23 steps of (unit latency + 2 cycles), plus 2 cycles.
REQ-023 Inputs P, Q, PQ and A SHALL be read directly, not latched; they must stay stable from rst deassertion until done.
REQ-024 Rx, Rz, Sx and Sz SHALL change only at capture of a step whose dst is that register.
REQ-025 A reset asserted mid-operation SHALL abort immediately; any late done_mul from the aborted step SHALL have no effect.

Reset
REQ-026 While rst is high, the block SHALL hold:
  - state = IDLE, step = 0
  - Rx = Rz = Sx = Sz = 0, temporaries a-d = 0
  - done = 0, rst_mul = 1
  - A = 0, B = 0, op = 00
REQ-027 Reset SHALL take effect asynchronously, without waiting for a clock edge.

Verification
REQ-028 Scenario, reset state: hold rst high with arbitrary inputs -> all REQ-026 values present; no rst_mul falling edge occurs.
REQ-029 Scenario, known result: unit model uses integer product mod p for op 00 and 1-cycle latency; inputs P=(3,1), Q=(2,1), PQ=(1,1), A=(0,1) -> Rx=256, Rz=480, Sx=100, Sz=4, done=1; exactly 23 rst_mul falling edges, the ops matching REQ-016.
REQ-030 Scenario, wrap-around subtraction: P=(1,3), other inputs as in REQ-029 -> step 4 result d = p-2; final outputs match the software golden xDBLADD mod p.
REQ-031 Scenario, latency independence: REQ-029 inputs with unit latency 1, 7 and 40 cycles, including random stalls -> identical outputs; done cycle count per REQ-022.
REQ-032 Scenario, abort and restart: assert rst asynchronously during WAIT of step 9 and deassert after 3 cycles -> outputs 0 and rst_mul = 1 immediately; the rerun yields the REQ-029 values.
REQ-033 Scenario, spurious handshake: pulse done_mul while rst_mul = 1 and while in DONE -> no register change; done stays 1.
